// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: routes a tagged word stream into two independent FIFO channels
module demux_1to2_buf #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out0_data,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [WIDTH-1:0]           out1_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH):0]     out0_count,
  output logic [$clog2(DEPTH):0]     out1_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0] wr_q [2];
  logic [AW-1:0] wr_d [2];
  logic [AW-1:0] rd_q [2];
  logic [AW-1:0] rd_d [2];
  logic [AW:0] cnt_q [2];
  logic [AW:0] cnt_d [2];
  logic [1:0] push, pop, valid;
  assign valid      = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign in_ready   = cnt_q[in_sel] != FULL;
  assign push       = {in_sel, ~in_sel} & {2{in_valid & in_ready}};
  assign pop        = valid & {out1_ready, out0_ready};
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem_q[0][rd_q[0]];
  assign out1_data  = mem_q[1][rd_q[1]];
  assign out0_count = cnt_q[0];
  assign out1_count = cnt_q[1];
  // Per-channel pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_d[c]  = push[c] ? wr_q[c] + AW'(1) : wr_q[c];
      rd_d[c]  = pop[c] ? rd_q[c] + AW'(1) : rd_q[c];
      cnt_d[c] = (push[c] && !pop[c]) ? cnt_q[c] + (AW+1)'(1) :
                 (pop[c] && !push[c]) ? cnt_q[c] - (AW+1)'(1) : cnt_q[c];
    end
  end
  // State registers and storage; reset discards all buffered words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[c][e] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]  <= wr_d[c];
        rd_q[c]  <= rd_d[c];
        cnt_q[c] <= cnt_d[c];
        if (push[c]) mem_q[c][wr_q[c]] <= in_data;
      end
    end
  end
endmodule
